// File: rtl/alu_issue_stage_if.sv
// ----------------------------------------------------------------------------
// alu_issue_stage_if
// Bundles every handshake, payload and forwarding signal of the ALU issue
// stage. clk and rstn stay plain ports on the stage itself.
//
// Modports:
//   master : the environment around the stage. It drives the upstream
//            instruction, the forwarding sources, flush and out_ready.
//   slave  : the issue stage. It drives in_ready, the out_* payload and
//            stall_cnt.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   A producer holding valid=1 keeps its payload stable until that edge.
//   ready may be 1 while valid is 0.
// ----------------------------------------------------------------------------
interface alu_issue_stage_if #(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5
);
   // upstream (decoded instruction)
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_alu_op;
   logic [5:0]        in_funct;
   logic [RA_W-1:0]   in_rs;
   logic [RA_W-1:0]   in_rt;
   logic [RA_W-1:0]   in_rd;
   logic [DATA_W-1:0] in_rs_data;
   logic [DATA_W-1:0] in_rt_data;
   logic [DATA_W-1:0] in_imm;
   logic              in_alu_src;
   logic              in_reg_write;
   logic              flush;
   // forwarding sources
   logic              fwd_mem_we;
   logic [RA_W-1:0]   fwd_mem_rd;
   logic [DATA_W-1:0] fwd_mem_data;
   logic              fwd_wb_we;
   logic [RA_W-1:0]   fwd_wb_rd;
   logic [DATA_W-1:0] fwd_wb_data;
   // downstream (ALU operands)
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_a;
   logic [DATA_W-1:0] out_b;
   logic [3:0]        out_alu_ctl;
   logic [DATA_W-1:0] out_store_data;
   logic [RA_W-1:0]   out_rd;
   logic              out_reg_write;
   logic              out_illegal;
   logic [15:0]       stall_cnt;

   modport master (
      output in_valid, in_alu_op, in_funct, in_rs, in_rt, in_rd,
             in_rs_data, in_rt_data, in_imm, in_alu_src, in_reg_write, flush,
             fwd_mem_we, fwd_mem_rd, fwd_mem_data,
             fwd_wb_we, fwd_wb_rd, fwd_wb_data, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_alu_ctl, out_store_data,
             out_rd, out_reg_write, out_illegal, stall_cnt
   );

   modport slave (
      input  in_valid, in_alu_op, in_funct, in_rs, in_rt, in_rd,
             in_rs_data, in_rt_data, in_imm, in_alu_src, in_reg_write, flush,
             fwd_mem_we, fwd_mem_rd, fwd_mem_data,
             fwd_wb_we, fwd_wb_rd, fwd_wb_data, out_ready,
      output in_ready, out_valid, out_a, out_b, out_alu_ctl, out_store_data,
             out_rd, out_reg_write, out_illegal, stall_cnt
   );
endinterface

// File: rtl/alu_issue_stage.sv
// ----------------------------------------------------------------------------
// alu_issue_stage
// ID/EX issue stage in front of the 32-bit ALU. Decodes ALUOp/funct into the
// 4-bit ALU control code, selects forwarded operands and the immediate, and
// holds the result in a two-entry OUT/SKID buffer so back-pressure from the
// ALU never drops an instruction.
//
// Ports:
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset; clears both entries immediately
//   bus  : alu_issue_stage_if.slave (upstream instruction, forwarding
//          sources, flush, downstream operands, stall_cnt)
//
// Build option:
//   ALU_ISSUE_FORWARDING_EN : when defined, the EX/MEM and MEM/WB forwarding
//   muxes are built (EX/MEM has priority, register 0 never forwards). When
//   undefined, the fwd_* inputs are ignored and operands come straight from
//   in_rs_data / in_rt_data / in_imm.
//
// Only DATA_W = 32 is meaningful; the ALU it feeds is fixed at 32 bits.
// ----------------------------------------------------------------------------
module alu_issue_stage #(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5
) (
   input logic             clk,
   input logic             rstn,
   alu_issue_stage_if.slave bus
);

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] store;
      logic [3:0]        ctl;
      logic [RA_W-1:0]   rd;
      logic              reg_write;
      logic              illegal;
   } entry_t;

   entry_t        r_out;
   entry_t        r_skid;
   logic          r_out_valid;
   logic          r_skid_valid;
   logic          r_in_ready;
   logic [15:0]   r_stall_cnt;

   logic [3:0]        w_ctl;
   logic              w_illegal;
   logic [DATA_W-1:0] w_rs_val;
   logic [DATA_W-1:0] w_rt_val;
   entry_t            w_entry;
   logic              w_accept;

   // ALUOp / funct decode
   always_comb begin
      w_ctl     = 4'b0010;
      w_illegal = 1'b0;
      case (bus.in_alu_op)
         2'b00: w_ctl = 4'b0010;
         2'b01: w_ctl = 4'b0110;
         2'b11: w_ctl = 4'b0111;
         default: begin
            case (bus.in_funct)
               6'b100000: w_ctl = 4'b0010;
               6'b100010: w_ctl = 4'b0110;
               6'b100100: w_ctl = 4'b0000;
               6'b100101: w_ctl = 4'b0001;
               6'b100111: w_ctl = 4'b1100;
               6'b101010: w_ctl = 4'b0111;
               default: begin
                  w_ctl     = 4'b0010;
                  w_illegal = 1'b1;
               end
            endcase
         end
      endcase
   end

`ifdef ALU_ISSUE_FORWARDING_EN
   // EX/MEM beats MEM/WB: it holds the younger value of the register.
   function automatic logic [DATA_W-1:0] fwd_sel(
      input logic [RA_W-1:0]   r,
      input logic [DATA_W-1:0] rf_data
   );
      if (r != '0 && bus.fwd_mem_we && bus.fwd_mem_rd == r)
         return bus.fwd_mem_data;
      else if (r != '0 && bus.fwd_wb_we && bus.fwd_wb_rd == r)
         return bus.fwd_wb_data;
      else
         return rf_data;
   endfunction

   assign w_rs_val = fwd_sel(bus.in_rs, bus.in_rs_data);
   assign w_rt_val = fwd_sel(bus.in_rt, bus.in_rt_data);
`else
   assign w_rs_val = bus.in_rs_data;
   assign w_rt_val = bus.in_rt_data;

   logic w_unused_fwd;
   assign w_unused_fwd = ^{bus.fwd_mem_we, bus.fwd_mem_rd, bus.fwd_mem_data,
                           bus.fwd_wb_we, bus.fwd_wb_rd, bus.fwd_wb_data,
                           bus.in_rs, bus.in_rt};
`endif

   always_comb begin
      w_entry.a         = w_rs_val;
      w_entry.b         = bus.in_alu_src ? bus.in_imm : w_rt_val;
      w_entry.store     = w_rt_val;
      w_entry.ctl       = w_ctl;
      w_entry.rd        = bus.in_rd;
      w_entry.reg_write = bus.in_reg_write;
      w_entry.illegal   = w_illegal;
   end

   assign w_accept = bus.in_valid & r_in_ready;

   // OUT/SKID buffer. SKID only fills while OUT is held, so OUT is never
   // empty while SKID is full. r_in_ready mirrors !SKID.valid as a flop.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_out        <= '0;
         r_skid       <= '0;
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
         r_stall_cnt  <= '0;
      end else begin
         if (r_out_valid && !bus.out_ready && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;

         if (bus.flush) begin
            // flush beats a simultaneous accept; payload left as don't-care
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
         end else if (!r_out_valid || bus.out_ready) begin
            if (r_skid_valid) begin
               r_out        <= r_skid;
               r_out_valid  <= 1'b1;
               r_skid_valid <= 1'b0;
               r_in_ready   <= 1'b1;
            end else if (w_accept) begin
               r_out       <= w_entry;
               r_out_valid <= 1'b1;
            end else begin
               r_out_valid <= 1'b0;
            end
         end else if (w_accept) begin
            r_skid       <= w_entry;
            r_skid_valid <= 1'b1;
            r_in_ready   <= 1'b0;
         end
      end
   end

   assign bus.in_ready       = r_in_ready;
   assign bus.out_valid      = r_out_valid;
   assign bus.out_a          = r_out.a;
   assign bus.out_b          = r_out.b;
   assign bus.out_store_data = r_out.store;
   assign bus.out_alu_ctl    = r_out.ctl;
   assign bus.out_rd         = r_out.rd;
   assign bus.out_reg_write  = r_out.reg_write;
   assign bus.out_illegal    = r_out.illegal;
   assign bus.stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ----------------------------------------------------------------------------
// tb_alu_issue_stage
// Self-checking bench for alu_issue_stage. Accepted instructions push their
// expected payload {a, b, store, ctl, rd, reg_write, illegal} onto exp_q; a
// negedge monitor pops and compares on every consumed output.
// ----------------------------------------------------------------------------
module tb_alu_issue_stage;

   localparam int PW = 107;

   logic clk;
   logic rstn;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   logic [PW-1:0] exp_q[$];

   alu_issue_stage_if bus ();

   alu_issue_stage dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic apply_reset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] fwd_model(input logic [4:0] r, input logic [31:0] rf);
`ifdef ALU_ISSUE_FORWARDING_EN
      if (r != 0 && bus.fwd_mem_we && bus.fwd_mem_rd == r) return bus.fwd_mem_data;
      if (r != 0 && bus.fwd_wb_we && bus.fwd_wb_rd == r) return bus.fwd_wb_data;
`endif
      return rf;
   endfunction

   function automatic logic [PW-1:0] model(
      input logic [1:0] op, input logic [5:0] funct,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
      input logic [31:0] rs_d, input logic [31:0] rt_d, input logic [31:0] imm,
      input logic alu_src, input logic rw
   );
      logic [3:0]  ctl;
      logic        ill;
      logic [31:0] a, rtv, b;
      ill = 1'b0;
      ctl = 4'b0010;
      if (op == 2'b01) ctl = 4'b0110;
      else if (op == 2'b11) ctl = 4'b0111;
      else if (op == 2'b10) begin
         case (funct)
            6'h20: ctl = 4'b0010;
            6'h22: ctl = 4'b0110;
            6'h24: ctl = 4'b0000;
            6'h25: ctl = 4'b0001;
            6'h27: ctl = 4'b1100;
            6'h2A: ctl = 4'b0111;
            default: ill = 1'b1;
         endcase
      end
      a   = fwd_model(rs, rs_d);
      rtv = fwd_model(rt, rt_d);
      b   = alu_src ? imm : rtv;
      return {a, b, rtv, ctl, rd, rw, ill};
   endfunction

   function automatic logic [PW-1:0] out_now();
      return {bus.out_a, bus.out_b, bus.out_store_data, bus.out_alu_ctl,
              bus.out_rd, bus.out_reg_write, bus.out_illegal};
   endfunction

   // ---------------- drivers ----------------
   task automatic set_fields(
      input logic [1:0] op, input logic [5:0] funct,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
      input logic [31:0] rs_d, input logic [31:0] rt_d, input logic [31:0] imm,
      input logic alu_src, input logic rw
   );
      bus.in_alu_op    = op;
      bus.in_funct     = funct;
      bus.in_rs        = rs;
      bus.in_rt        = rt;
      bus.in_rd        = rd;
      bus.in_rs_data   = rs_d;
      bus.in_rt_data   = rt_d;
      bus.in_imm       = imm;
      bus.in_alu_src   = alu_src;
      bus.in_reg_write = rw;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(
      input logic [1:0] op, input logic [5:0] funct,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
      input logic [31:0] rs_d, input logic [31:0] rt_d, input logic [31:0] imm,
      input logic alu_src, input logic rw
   );
      logic [PW-1:0] e;
      logic rdy, ok;
      set_fields(op, funct, rs, rt, rd, rs_d, rt_d, imm, alu_src, rw);
      e = model(op, funct, rs, rt, rd, rs_d, rt_d, imm, alu_src, rw);
      bus.in_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         #1;
         if (rdy) ok = 1'b1;
      end
      bus.in_valid = 1'b0;
      checks++;
      if (ok) exp_q.push_back(e);
      else begin
         failures++;
         $display("FAIL send_timeout got in_ready=0 for 100 cycles exp accept");
      end
   endtask

   task automatic send_rand();
      logic [5:0] functs[7];
      functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00};
      send(2'($urandom_range(0, 3)), functs[$urandom_range(0, 6)],
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
           $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rstn && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_unexpected got %h exp none", out_now());
         end else begin
            logic [PW-1:0] e;
            e = exp_q.pop_front();
            if (out_now() !== e) begin
               failures++;
               $display("FAIL scoreboard got %h exp %h", out_now(), e);
            end
         end
      end
   end

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.stall_cnt !== 16'd0 ||
          out_now() !== '0) begin
         failures++;
         $display("FAIL reset_state got v=%b rdy=%b stall=%0d pay=%h exp v=0 rdy=1 stall=0 pay=0",
                  bus.out_valid, bus.in_ready, bus.stall_cnt, out_now());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_rtype();
      logic [5:0] functs[7];
      functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         send(2'b10, functs[i], 5'd1, 5'd2, 5'd3, 32'd5, 32'd3, 32'd0, 1'b0, 1'b1);
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rtype_latency funct=%h got out_valid=%b exp 1", functs[i], bus.out_valid);
         end
         @(posedge clk);
         #1;
      end
      send(2'b00, 6'h3F, 5'd1, 5'd2, 5'd3, 32'd5, 32'd3, 32'd16, 1'b1, 1'b1);
      send(2'b01, 6'h3F, 5'd1, 5'd2, 5'd3, 32'd5, 32'd3, 32'd16, 1'b0, 1'b0);
      send(2'b11, 6'h3F, 5'd1, 5'd2, 5'd3, 32'd5, 32'd3, 32'd16, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_forward();
      logic [31:0] exp_a;
      bus.out_ready    = 1'b1;
      bus.fwd_mem_we   = 1'b1;
      bus.fwd_mem_rd   = 5'd4;
      bus.fwd_mem_data = 32'hAAAA0000;
      bus.fwd_wb_we    = 1'b1;
      bus.fwd_wb_rd    = 5'd4;
      bus.fwd_wb_data  = 32'h00005555;
`ifdef ALU_ISSUE_FORWARDING_EN
      exp_a = 32'hAAAA0000;
`else
      exp_a = 32'h00001234;
`endif
      send(2'b00, 6'h00, 5'd4, 5'd6, 5'd8, 32'h1234, 32'h9999, 32'd0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.out_a !== exp_a) begin
         failures++;
         $display("FAIL fwd_priority got out_a=%h exp %h", bus.out_a, exp_a);
      end
      @(posedge clk);
      #1;
      // rs=0 never forwards
      bus.fwd_mem_rd = 5'd0;
      bus.fwd_wb_rd  = 5'd0;
      send(2'b00, 6'h00, 5'd0, 5'd0, 5'd8, 32'h1234, 32'h9999, 32'd0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.out_a !== 32'h1234) begin
         failures++;
         $display("FAIL fwd_r0 got out_a=%h exp 00001234", bus.out_a);
      end
      @(posedge clk);
      #1;
      // wb source on rt, mem source on a different register
      bus.fwd_mem_rd = 5'd9;
      bus.fwd_wb_rd  = 5'd7;
      send(2'b10, 6'h20, 5'd4, 5'd7, 5'd8, 32'h1234, 32'h9999, 32'd0, 1'b0, 1'b1);
      bus.fwd_mem_we = 1'b0;
      bus.fwd_wb_we  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int start;
      bus.out_ready = 1'b1;
      start = cyc;
      for (int i = 0; i < 8; i++) send_rand();
      checks++;
      if (cyc - start != 8) begin
         failures++;
         $display("FAIL throughput got %0d cycles exp 8", cyc - start);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      bit done = 0;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               bus.fwd_mem_we   = 1'($urandom_range(0, 1));
               bus.fwd_mem_rd   = 5'($urandom_range(0, 3));
               bus.fwd_mem_data = $urandom;
               bus.fwd_wb_we    = 1'($urandom_range(0, 1));
               bus.fwd_wb_rd    = 5'($urandom_range(0, 3));
               bus.fwd_wb_data  = $urandom;
               send_rand();
            end
            done = 1;
         end
         begin
            while (!done) begin
               bus.out_ready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
         end
      join
      bus.out_ready  = 1'b1;
      bus.fwd_mem_we = 1'b0;
      bus.fwd_wb_we  = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      apply_reset();
      bus.out_ready = 1'b0;
      send(2'b10, 6'h20, 5'd1, 5'd2, 5'd10, 32'h11, 32'h1, 32'd0, 1'b0, 1'b1);
      send(2'b10, 6'h22, 5'd1, 5'd2, 5'd11, 32'h22, 32'h2, 32'd0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL bp_full got in_ready=%b out_valid=%b exp 0 1", bus.in_ready, bus.out_valid);
      end
      @(posedge clk);
      #1;
      // already one hold edge after I2 accept; two more in the loop below
      fork
         send(2'b10, 6'h24, 5'd1, 5'd2, 5'd12, 32'h33, 32'h3, 32'd0, 1'b0, 1'b0);
         begin
            repeat (2) begin
               @(negedge clk);
               checks++;
               if (bus.in_ready !== 1'b0 || out_now() !== exp_q[0]) begin
                  failures++;
                  $display("FAIL bp_hold got in_ready=%b pay=%h exp 0 %h",
                           bus.in_ready, out_now(), exp_q[0]);
               end
               @(posedge clk);
            end
            #1 bus.out_ready = 1'b1;
         end
      join
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.stall_cnt !== 16'd4 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL bp_stall_cnt got stall=%0d pending=%0d exp 4 0", bus.stall_cnt, exp_q.size());
      end
   endtask

   task automatic test_flush();
      bus.out_ready = 1'b0;
      send(2'b00, 6'h00, 5'd1, 5'd2, 5'd20, 32'h44, 32'h4, 32'd0, 1'b0, 1'b1);
      send(2'b01, 6'h00, 5'd1, 5'd2, 5'd21, 32'h55, 32'h5, 32'd0, 1'b0, 1'b1);
      set_fields(2'b11, 6'h00, 5'd1, 5'd2, 5'd22, 32'h66, 32'h6, 32'd0, 1'b0, 1'b1);
      bus.in_valid = 1'b1;
      bus.flush    = 1'b1;
      @(posedge clk);
      #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.stall_cnt !== 16'd6) begin
         failures++;
         $display("FAIL flush got out_valid=%b in_ready=%b stall=%0d exp 0 1 6",
                  bus.out_valid, bus.in_ready, bus.stall_cnt);
      end
      bus.out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_async_reset();
      bus.out_ready = 1'b0;
      send(2'b10, 6'h27, 5'd1, 5'd2, 5'd30, 32'hF0F0, 32'h0F0F, 32'd0, 1'b0, 1'b1);
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.stall_cnt !== 16'd0 ||
          out_now() !== '0) begin
         failures++;
         $display("FAIL async_reset got v=%b rdy=%b stall=%0d pay=%h exp v=0 rdy=1 stall=0 pay=0",
                  bus.out_valid, bus.in_ready, bus.stall_cnt, out_now());
      end
      exp_q.delete();
      @(negedge clk);
      #2 rstn = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send(2'b10, 6'h25, 5'd1, 5'd2, 5'd31, 32'h5, 32'h3, 32'd0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_latency got out_valid=%b exp 1", bus.out_valid);
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid     = 1'b0;
      bus.flush        = 1'b0;
      bus.out_ready    = 1'b0;
      bus.fwd_mem_we   = 1'b0;
      bus.fwd_mem_rd   = '0;
      bus.fwd_mem_data = '0;
      bus.fwd_wb_we    = 1'b0;
      bus.fwd_wb_rd    = '0;
      bus.fwd_wb_data  = '0;
      set_fields(2'b00, 6'h00, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      apply_reset();
      test_reset();
      test_rtype();
      test_forward();
      test_back_to_back();
      test_random();
      test_backpressure();
      test_flush();
      test_async_reset();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got %0d pending exp 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX issue stage that sits directly upstream of the 32-bit ALU and feeds its `a`, `b` and `ALU_ctl` inputs. It accepts one decoded instruction per cycle over a valid/ready handshake and decodes ALUOp/funct into the 4-bit ALU control code. It selects forwarded operands and the immediate, then holds the result in a two-entry output/skid buffer so downstream back-pressure never drops an instruction.

## Interface
- `DATA_W`, 32, operand width; only 32 is supported (ALU is fixed 32-bit)
- `RA_W`, 5, register-address width
- `clk`  in  1  sole clock, rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream instruction valid
- `in_ready`  out  1  stage can accept this cycle
- `in_alu_op`  in  2  ALUOp from main control
- `in_funct`  in  6  R-type funct field
- `in_rs`, `in_rt`, `in_rd`  in  RA_W each  source/destination register numbers
- `in_rs_data`, `in_rt_data`  in  DATA_W each  register-file read data
- `in_imm`  in  DATA_W  sign-extended immediate
- `in_alu_src`  in  1  1 = operand B is `in_imm`
- `in_reg_write`  in  1  instruction writes `in_rd`
- `flush`  in  1  discard all buffered and accepting instructions
- `fwd_mem_we`, `fwd_mem_rd`, `fwd_mem_data`  in  1/RA_W/DATA_W  EX/MEM forwarding source
- `fwd_wb_we`, `fwd_wb_rd`, `fwd_wb_data`  in  1/RA_W/DATA_W  MEM/WB forwarding source
- `out_valid`  out  1  issued instruction valid
- `out_ready`  in  1  ALU/EX stage consumes this cycle
- `out_a`, `out_b`  out  DATA_W each  ALU operands
- `out_alu_ctl`  out  4  ALU control code
- `out_store_data`  out  DATA_W  forwarded rt value (for stores)
- `out_rd`, `out_reg_write`  out  RA_W/1  passed through
- `out_illegal`  out  1  funct not recognised
- `stall_cnt`  out  16  saturating count of back-pressure cycles

## Operation
- Decode ALUOp 00 -> 0010 (add); ALUOp 01 -> 0110 (sub); ALUOp 11 -> 0111 (slt).
- ALUOp 10, funct 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 100111 -> 1100 (nor), 101010 -> 0111.
- Any other funct under ALUOp 10 -> 0010 with `out_illegal`=1.
- Forwarding per source register r, in priority order:
  - if `fwd_mem_we` and `fwd_mem_rd`==r and r!=0, take `fwd_mem_data`;
  - else the same test on the wb source, taking `fwd_wb_data`;
  - else register-file data.
- r==0 never forwards.
- `out_a` = forwarded rs; `out_store_data` = forwarded rt; `out_b` = `in_imm` if `in_alu_src`, else forwarded rt.
- Decode and forwarding are evaluated combinationally in the accept cycle and captured into the entry.
- Buffer: output register (OUT) plus skid register (SKID).
  - `in_ready` = !SKID.valid, driven from a flop.
  - Accept = `in_valid` & `in_ready`.
  - Accept when OUT empty, or OUT consumed the same cycle with SKID empty: entry loads OUT.
  - Accept when OUT held (`out_valid` & !`out_ready`): entry loads SKID.
  - OUT consumed while SKID full: SKID moves to OUT and `in_ready` rises the next cycle.
- Order is preserved; no entry is ever dropped or duplicated except by flush.
- `flush` clears OUT.valid and SKID.valid at the next edge and wins over a simultaneous accept; that instruction is discarded.
- `stall_cnt` increments each cycle with `out_valid` & !`out_ready` and saturates at 0xFFFF. Flush does not clear it; only reset does.

## Timing
- Latency: accept at edge N -> `out_valid` from edge N+1 when the buffer is empty.
- Throughput: one instruction per cycle while `out_ready`=1.
- Reset (asynchronous, `rstn`=0): all `out_*` = 0, `out_alu_ctl`=0000, `out_valid`=0, `in_ready`=1, `stall_cnt`=0.
- Reset mid-operation discards both entries immediately, without waiting for a clock edge.
- `out_*` payload stays stable while `out_valid` & !`out_ready`.
- Payload of an invalid entry is don't-care but must not be X after reset.

## Configuration
- `ALU_ISSUE_FORWARDING_EN` defined: forwarding muxes present as described.
- `ALU_ISSUE_FORWARDING_EN` undefined: all `fwd_*` inputs are ignored, and operands come straight from `in_rs_data`/`in_rt_data`/`in_imm`.

## Test plan
- R-type sweep: ALUOp 10 with each of the six functs, operands 5 and 3 -> `out_alu_ctl` 0010/0110/0000/0001/1100/0111 one cycle after accept; funct 000000 -> 0010 with `out_illegal`=1.
- Forward priority: rs=4, `fwd_mem_rd`=4 (data 0xAAAA0000), `fwd_wb_rd`=4 (data 0x5555) -> `out_a`=0xAAAA0000. Repeat with rs=0 -> register-file data. With the macro undefined -> register-file data.
- Back-pressure: hold `out_ready`=0 and stream I1, I2, I3.
  - I1 sits in OUT, I2 goes to SKID, `in_ready`=0, I3 is held upstream.
  - Release `out_ready`: outputs I1, I2, I3 in order; `stall_cnt` equals the held cycles.
- Flush while full, with `in_valid`=1: next cycle `out_valid`=0, `in_ready`=1, and the flushed instructions never appear.
- Async reset asserted mid-stream between edges: outputs go to zero immediately; after release the first accepted instruction appears with 1-cycle latency.
